// File: rtl/larpix_stim_sched.sv
// larpix_stim_sched: round-robin scheduler for charge-injection stimulus.
// Requesting channels are arbitrated fairly, each injection is clamped to
// MAX_E, and a 64-bit tag describing the injection is offered downstream.
module larpix_stim_sched #(
   parameter int NUMCHANNELS  = 32,
   parameter int CHAN_BITS    = 5,
   parameter int CHARGE_WIDTH = 16,
   parameter int MAX_E        = 20000,
   parameter int DEADTIME     = 16
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                enable,
   input  logic [7:0]                          chip_id,
   input  logic [NUMCHANNELS-1:0]              req,
   input  logic [NUMCHANNELS*CHARGE_WIDTH-1:0] req_charge,
   output logic [NUMCHANNELS-1:0]              grant,
   output logic                                inject_valid,
   output logic [CHAN_BITS-1:0]                inject_chan,
   output logic [CHARGE_WIDTH-1:0]             inject_charge,
   output logic                                tag_valid,
   input  logic                                tag_ready,
   output logic [63:0]                         tag_out,
   output logic [31:0]                         inject_count,
   output logic [1:0]                          dbg_state_o
);

   // Tag handshake: a tag transfers on a rising clk edge where tag_valid and
   // tag_ready are both 1. Once tag_valid rises, tag_out stays stable and
   // tag_valid stays high until that transfer; tag_valid never depends on
   // tag_ready.

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARB   = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;
   localparam logic [1:0] ST_WAIT  = 2'd3;

   localparam int                      DT_BITS  = $clog2(DEADTIME + 1);
   // Loading DEADTIME-1 makes the channel win again no earlier than
   // DEADTIME+1 cycles after its ISSUE cycle.
   localparam logic [DT_BITS-1:0]      DT_LOAD  = DT_BITS'(DEADTIME - 1);
   localparam logic [CHARGE_WIDTH-1:0] MAX_E_C  = CHARGE_WIDTH'(MAX_E);
   localparam logic [CHAN_BITS-1:0]    LAST_CH  = CHAN_BITS'(NUMCHANNELS - 1);
   localparam logic [NUMCHANNELS-1:0]  ONE_HOT0 = NUMCHANNELS'(1);

   logic [1:0]              state_q, state_d;
   logic [CHAN_BITS-1:0]    rr_q, rr_d;
   logic [CHAN_BITS-1:0]    chan_q, chan_d;
   logic [CHARGE_WIDTH-1:0] charge_q, charge_d;
   logic [63:0]             tag_q, tag_d;
   logic [31:0]             count_q, count_d;
   logic [31:0]             ts_q;

   logic [NUMCHANNELS-1:0]  eligible;
   logic [CHARGE_WIDTH-1:0] charge_arr [NUMCHANNELS];
   logic                    found;
   logic [CHAN_BITS-1:0]    win;
   logic [CHAN_BITS-1:0]    cand;
   logic [CHARGE_WIDTH-1:0] win_charge;
   logic [63:0]             tag_live;
   logic                    in_issue;

   assign in_issue = (state_q == ST_ISSUE);

   // Per-channel dead-time counter: reload on this channel's injection, else count down to 0
   for (genvar n = 0; n < NUMCHANNELS; n++) begin : g_ch
      logic [DT_BITS-1:0] dt_q;

      assign charge_arr[n] = req_charge[n*CHARGE_WIDTH +: CHARGE_WIDTH];
      assign eligible[n]   = req[n] && (dt_q == '0);

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            dt_q <= '0;
         end else if (in_issue && (chan_q == CHAN_BITS'(n))) begin
            dt_q <= DT_LOAD;
         end else if (dt_q != '0) begin
            dt_q <= dt_q - 1'b1;
         end
      end
   end

   // Free-running timestamp stamped into every tag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + 32'd1;
      end
   end

   // Round-robin search: first eligible channel starting at rr_q, wrapping
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NUMCHANNELS; k++) begin
         cand = CHAN_BITS'((int'(rr_q) + k) % NUMCHANNELS);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign win_charge = (charge_arr[win] > MAX_E_C) ? MAX_E_C : charge_arr[win];
   assign tag_live   = {ts_q, chip_id, 8'(chan_q), 16'(charge_q)};

   // Scheduler next-state: arbitrate, issue one injection, hold the tag until accepted
   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      chan_d   = chan_q;
      charge_d = charge_q;
      tag_d    = tag_q;
      count_d  = count_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (found) begin
               state_d  = ST_ISSUE;
               chan_d   = win;
               charge_d = win_charge;
            end
         end
         ST_ISSUE: begin
            tag_d   = tag_live;
            count_d = count_q + 32'd1;
            rr_d    = (chan_q == LAST_CH) ? '0 : chan_q + 1'b1;
            state_d = tag_ready ? ST_ARB : ST_WAIT;
         end
         ST_WAIT: begin
            if (tag_ready) state_d = ST_ARB;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Scheduler registers; reset drops any pending tag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         rr_q     <= '0;
         chan_q   <= '0;
         charge_q <= '0;
         tag_q    <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         chan_q   <= chan_d;
         charge_q <= charge_d;
         tag_q    <= tag_d;
         count_q  <= count_d;
      end
   end

   assign grant         = in_issue ? (ONE_HOT0 << chan_q) : '0;
   assign inject_valid  = in_issue;
   assign inject_chan   = chan_q;
   assign inject_charge = charge_q;
   assign tag_valid     = in_issue || (state_q == ST_WAIT);
   assign tag_out       = in_issue ? tag_live : tag_q;
   assign inject_count  = count_q;
   assign dbg_state_o   = state_q;

endmodule
